// File: rtl/maprom_load_tracker_pkg.sv
// Shared constants for the MapROM load tracker: FSM encoding and ROM window geometry.
package maprom_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_LOADING = 2'd1;
  localparam state_t ST_DONE    = 2'd2;
  localparam state_t ST_FAULT   = 2'd3;

  localparam logic [23:0] ROM_BASE   = 24'hF8_0000;
  localparam int          PAGE_W_DEF = 7;
  localparam logic [6:0]  LAST_PAGE  = 7'h7F;

endpackage

// File: rtl/maprom_load_tracker_strobe_sync_edge.sv
// Brings the asynchronous combined data strobe into the clk domain and emits a
// single-cycle pulse on each falling edge (one pulse per bus cycle).
module strobe_sync_edge (
  input  logic clk,
  input  logic maprom_rst,
  input  logic strb_n,
  output logic ev
);

  logic [1:0] sync_r;
  logic       prev_r;

  // Idle level of the strobe is high, so reset to 1 to avoid a spurious pulse.
  always_ff @(posedge clk or posedge maprom_rst) begin
    if (maprom_rst) begin
      sync_r <= 2'b11;
      prev_r <= 1'b1;
      ev     <= 1'b0;
    end else begin
      sync_r <= {sync_r[0], strb_n};
      prev_r <= sync_r[1];
      ev     <= prev_r & ~sync_r[1];
    end
  end

endmodule

// File: rtl/maprom_load_tracker.sv
// Qualifies an ordered, complete Kickstart load into the F80000-FFFFFF shadow
// window before MapROM is allowed to engage.
module maprom_load_tracker
  import maprom_pkg::*;
#(
  parameter int PAGE_W  = PAGE_W_DEF,
  parameter int MIN_WR  = 16,
  parameter int CNT_W   = 5,
  parameter int TIMEOUT = 1 << 20,
  parameter int TO_W    = 21
) (
  input  logic                 clk,
  input  logic                 maprom_rst,
  input  logic [PAGE_W+11:12]  ah,
  input  logic                 rom_range,
  input  logic                 rw,
  input  logic                 _uds,
  input  logic                 _lds,
  input  logic                 maprom_on,
  output logic                 maprom_loaded,
  output logic                 maprom_fault,
  output logic [PAGE_W-1:0]    progress
);

  localparam logic [PAGE_W-1:0] PAGE_ZERO = {PAGE_W{1'b0}};
  localparam logic [PAGE_W-1:0] LAST_PG   = {PAGE_W{1'b1}};
  localparam logic [PAGE_W:0]   PAGE_ONE  = {{PAGE_W{1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_MIN   = CNT_W'(MIN_WR);
  localparam logic [TO_W-1:0]   TO_ZERO   = {TO_W{1'b0}};
  localparam logic [TO_W-1:0]   TO_ONE    = {{(TO_W-1){1'b0}}, 1'b1};
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT - 1);

  logic              ev_s;
  logic              q_s;
  logic [PAGE_W-1:0] page_s;
  logic [PAGE_W:0]   next_page_s;
  logic              bad_s;

  state_t            state_r, state_n;
  logic [PAGE_W-1:0] cur_r, cur_n;
  logic [CNT_W-1:0]  cnt_r, cnt_n;
  logic [TO_W-1:0]   to_r, to_n;

  strobe_sync_edge u_strobe (
    .clk        (clk),
    .maprom_rst (maprom_rst),
    .strb_n     (_uds & _lds),
    .ev         (ev_s)
  );

  assign page_s      = ah;
  assign q_s         = ev_s & rom_range & ~rw & ~maprom_on;
  // One bit wider than the page index so the last page never wraps to page 0.
  assign next_page_s = {1'b0, cur_r} + PAGE_ONE;

  // Next-state, page/count and timeout evaluation.
  always_comb begin
    state_n = state_r;
    cur_n   = cur_r;
    cnt_n   = cnt_r;
    to_n    = to_r;
    bad_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (q_s && (page_s == PAGE_ZERO)) begin
          state_n = ST_LOADING;
          cur_n   = PAGE_ZERO;
          cnt_n   = CNT_ONE;
          to_n    = TO_ZERO;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_LOADING: begin
        if (q_s) begin
          to_n = TO_ZERO;
          if (page_s == cur_r) begin
            cnt_n = (cnt_r == CNT_MAX) ? cnt_r : cnt_r + CNT_ONE;
          end else if (page_s < cur_r) begin
            cnt_n = cnt_r;
          end else if (({1'b0, page_s} == next_page_s) && (cnt_r >= CNT_MIN)) begin
            cur_n = page_s;
            cnt_n = CNT_ONE;
          end else begin
            bad_s = 1'b1;
          end
          if (bad_s) begin
            state_n = ST_FAULT;
          end else if ((cur_n == LAST_PG) && (cnt_n >= CNT_MIN)) begin
            state_n = ST_DONE;
          end else begin
            state_n = ST_LOADING;
          end
        end else if (!maprom_on) begin
          if (to_r == TO_LAST) begin
            state_n = ST_FAULT;
          end else begin
            to_n = to_r + TO_ONE;
          end
        end else begin
          to_n = to_r;
        end
      end
      ST_DONE: begin
        state_n = ST_DONE;
      end
      ST_FAULT: begin
        state_n = ST_FAULT;
      end
      default: begin
        state_n = ST_FAULT;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge maprom_rst) begin
    if (maprom_rst) begin
      state_r       <= ST_IDLE;
      cur_r         <= PAGE_ZERO;
      cnt_r         <= {CNT_W{1'b0}};
      to_r          <= TO_ZERO;
      maprom_loaded <= 1'b0;
      maprom_fault  <= 1'b0;
      progress      <= PAGE_ZERO;
    end else begin
      state_r       <= state_n;
      cur_r         <= cur_n;
      cnt_r         <= cnt_n;
      to_r          <= to_n;
      maprom_loaded <= (state_n == ST_DONE);
      maprom_fault  <= (state_n == ST_FAULT);
      progress      <= cur_n;
    end
  end

endmodule

// File: tb/tb_maprom_load_tracker.sv
// Directed bench for maprom_load_tracker: a vector table for single bus cycles
// plus hand-written sequences for full loads, faults, timeout and reset.
module tb_maprom_load_tracker;
  import maprom_pkg::*;

  logic       clk = 1'b0;
  logic       maprom_rst;
  logic [6:0] ah;
  logic       rom_range, rw, uds, lds, maprom_on;
  logic       maprom_loaded, maprom_fault;
  logic [6:0] progress;

  int checks   = 0;
  int failures = 0;

  maprom_load_tracker #(.TIMEOUT(64)) dut (
    .clk           (clk),
    .maprom_rst    (maprom_rst),
    .ah            (ah),
    .rom_range     (rom_range),
    .rw            (rw),
    ._uds          (uds),
    ._lds          (lds),
    .maprom_on     (maprom_on),
    .maprom_loaded (maprom_loaded),
    .maprom_fault  (maprom_fault),
    .progress      (progress)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] page;
    logic       rd;
    logic       rr;
    logic       mon;
    logic       use_lds;
    logic       e_ld;
    logic       e_ft;
    logic [6:0] e_pg;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    maprom_rst = 1'b1;
    repeat (2) @(negedge clk);
    maprom_rst = 1'b0;
    @(negedge clk);
  endtask

  // One bus cycle: address phase, strobe low for 5 clk, strobe released.
  task automatic bus_cycle(input logic [6:0] page, input logic rd, input logic rr,
                           input logic mon, input logic use_lds);
    logic [23:0] addr;
    addr = ROM_BASE + {5'b0, page, 12'h000};
    @(negedge clk);
    ah = addr[18:12]; rw = rd; rom_range = rr; maprom_on = mon;
    @(negedge clk);
    if (use_lds) lds = 1'b0; else uds = 1'b0;
    repeat (5) @(negedge clk);
    uds = 1'b1; lds = 1'b1;
    @(negedge clk);
    rw = 1'b1; rom_range = 1'b0;
  endtask

  task automatic wr(input logic [6:0] page, input int n);
    for (int i = 0; i < n; i++) bus_cycle(page, 1'b0, 1'b1, 1'b0, i[0]);
  endtask

  initial begin
    maprom_rst = 1'b1; ah = 7'h00; rom_range = 1'b0; rw = 1'b1;
    uds = 1'b1; lds = 1'b1; maprom_on = 1'b0;

    vecs[0]  = '{7'h40, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'h00};
    vecs[1]  = '{7'h40, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'h00};
    vecs[2]  = '{7'h40, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 7'h00};
    vecs[3]  = '{7'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'h00};
    vecs[4]  = '{7'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'h00};
    vecs[5]  = '{7'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 7'h00};
    vecs[6]  = '{7'h01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'h00};
    vecs[7]  = '{7'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'h00};
    vecs[8]  = '{7'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 7'h00};
    vecs[9]  = '{7'h01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 7'h00};
    vecs[10] = '{7'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 7'h00};

    repeat (2) @(negedge clk);
    chk("reset_loaded", {31'b0, maprom_loaded}, 32'd0);
    chk("reset_fault", {31'b0, maprom_fault}, 32'd0);
    chk("reset_progress", {25'b0, progress}, 32'd0);
    maprom_rst = 1'b0;

    // Vector table: noise from IDLE, non-qualifying cycles, entry and early advance.
    for (int i = 0; i < 11; i++) begin
      bus_cycle(vecs[i].page, vecs[i].rd, vecs[i].rr, vecs[i].mon, vecs[i].use_lds);
      chk($sformatf("vec%0d_loaded", i), {31'b0, maprom_loaded}, {31'b0, vecs[i].e_ld});
      chk($sformatf("vec%0d_fault", i), {31'b0, maprom_fault}, {31'b0, vecs[i].e_ft});
      chk($sformatf("vec%0d_progress", i), {25'b0, progress}, {25'b0, vecs[i].e_pg});
    end

    // Full ordered load with a rewrite, counter saturation and no wrap at the last page.
    do_reset();
    for (int p = 0; p < 127; p++) begin
      if (p == 3) wr(7'd1, 1);
      wr(p[6:0], (p == 2) ? 40 : 16);
    end
    chk("load_prog126", {25'b0, progress}, 32'd126);
    wr(LAST_PAGE, 5);
    wr(7'h00, 1);
    chk("nowrap_fault", {31'b0, maprom_fault}, 32'd0);
    chk("nowrap_progress", {25'b0, progress}, 32'd127);
    wr(LAST_PAGE, 10);
    chk("load_not_yet", {31'b0, maprom_loaded}, 32'd0);
    @(negedge clk);
    ah = LAST_PAGE; rw = 1'b0; rom_range = 1'b1;
    @(negedge clk);
    uds = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("load_lat3", {31'b0, maprom_loaded}, 32'd0);
    @(posedge clk);
    #1 chk("load_lat4", {31'b0, maprom_loaded}, 32'd1);
    repeat (2) @(negedge clk);
    uds = 1'b1;
    @(negedge clk);
    rw = 1'b1; rom_range = 1'b0;
    chk("load_progress", {25'b0, progress}, 32'd127);
    chk("load_fault", {31'b0, maprom_fault}, 32'd0);
    wr(7'd5, 1);
    chk("done_ignore_fault", {31'b0, maprom_fault}, 32'd0);
    chk("done_sticky", {31'b0, maprom_loaded}, 32'd1);

    // Skip a page, then asynchronous reset clears the fault.
    do_reset();
    for (int p = 0; p < 5; p++) wr(p[6:0], 16);
    chk("skip_pre_fault", {31'b0, maprom_fault}, 32'd0);
    wr(7'd6, 1);
    chk("skip_fault", {31'b0, maprom_fault}, 32'd1);
    chk("skip_progress", {25'b0, progress}, 32'd4);
    @(posedge clk);
    #3 maprom_rst = 1'b1;
    #1 chk("arst_fault", {31'b0, maprom_fault}, 32'd0);
    chk("arst_progress", {25'b0, progress}, 32'd0);
    @(negedge clk);
    maprom_rst = 1'b0;

    // Advance before MIN_WR writes.
    do_reset();
    wr(7'd0, 10);
    chk("minwr_pre", {31'b0, maprom_fault}, 32'd0);
    wr(7'd1, 1);
    chk("minwr_fault", {31'b0, maprom_fault}, 32'd1);
    chk("minwr_progress", {25'b0, progress}, 32'd0);

    // Timeout: 64 clk after the edge that consumed the last qualified write.
    do_reset();
    @(negedge clk);
    ah = 7'd0; rw = 1'b0; rom_range = 1'b1;
    @(negedge clk);
    uds = 1'b0;
    repeat (4) @(posedge clk);
    for (int k = 1; k <= 64; k++) begin
      @(negedge clk);
      if (k == 2) uds = 1'b1;
      if (k == 5) begin rw = 1'b1; lds = 1'b0; end
      if (k == 12) lds = 1'b1;
      if (k == 20) begin rw = 1'b0; rom_range = 1'b0; uds = 1'b0; end
      if (k == 27) uds = 1'b1;
      @(posedge clk);
      #1;
      if (k == 63) chk("timeout_63", {31'b0, maprom_fault}, 32'd0);
      if (k == 64) chk("timeout_64", {31'b0, maprom_fault}, 32'd1);
    end
    rw = 1'b1; rom_range = 1'b0;

    // maprom_on blocks everything and pauses the timeout.
    do_reset();
    for (int p = 0; p < 128; p++) begin
      for (int w = 0; w < 16; w++) bus_cycle(p[6:0], 1'b0, 1'b1, 1'b1, 1'b0);
    end
    chk("mon_loaded", {31'b0, maprom_loaded}, 32'd0);
    chk("mon_progress", {25'b0, progress}, 32'd0);
    chk("mon_fault", {31'b0, maprom_fault}, 32'd0);
    maprom_on = 1'b0;
    wr(7'd0, 16);
    wr(7'd1, 3);
    chk("mon_mid_progress", {25'b0, progress}, 32'd1);
    maprom_on = 1'b1;
    repeat (100) @(negedge clk);
    bus_cycle(7'd2, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("mon_pause_fault", {31'b0, maprom_fault}, 32'd0);
    maprom_on = 1'b0;
    wr(7'd1, 1);
    chk("mon_resume_fault", {31'b0, maprom_fault}, 32'd0);
    chk("mon_resume_progress", {25'b0, progress}, 32'd1);
    @(posedge clk);
    #3 maprom_rst = 1'b1;
    #1 chk("mid_rst_progress", {25'b0, progress}, 32'd0);
    chk("mid_rst_loaded", {31'b0, maprom_loaded}, 32'd0);
    chk("mid_rst_fault", {31'b0, maprom_fault}, 32'd0);
    @(negedge clk);
    maprom_rst = 1'b0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
